prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory loader that writes 16-bit instruction words into the processor's 32-entry program RAM from a byte-stream source (UART receiver or debug bridge). It parses a framed byte stream of word count, instruction words and XOR checksum, and issues one write per word to the program memory write port. It holds the processor in reset during loading and releases it only after a frame passes the checksum. It sits between the host-side byte source and the program memory, driving the processor's external active-low reset input.

## Interface
- ADDR_W, 5, program memory address width (matches the processor program counter)
- DEPTH, 32, number of program memory words; legal word count is 1..DEPTH
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a load frame
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  program memory write strobe, one-cycle pulse per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  instruction word: {high byte, low byte}
- cpu_rstn  out  1  active-low reset to processor; 0 holds processor in reset
- busy  out  1  frame in progress
- done  out  1  last frame loaded with a good checksum (sticky)
- err  out  1  last frame rejected (sticky)

## Operation
- Frame: COUNT byte N, then N words each sent as high byte then low byte, then CHK byte. CHK is the XOR of all 2N data bytes. The COUNT byte is excluded from CHK.
- A byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a Moore output: 1 in COUNT, HI, LO and CHK, 0 elsewhere. byte_data is ignored while byte_valid is 0.
- States:
  - IDLE: cpu_rstn=0.
  - COUNT
  - HI
  - LO
  - CHK
  - DONE: cpu_rstn=1.
  - ERR: cpu_rstn=0.
- Transitions:
  - IDLE/DONE/ERR + start -> COUNT. On entry: done=0, err=0, cpu_rstn=0, addr counter=0, running XOR=0, busy=1.
  - start is ignored in COUNT, HI, LO and CHK.
  - COUNT + transfer:
    - N==0 or N>DEPTH -> ERR.
    - Otherwise latch remaining=N and go to HI.
  - HI + transfer: latch high byte, XOR into checksum, go to LO.
  - LO + transfer:
    - XOR the byte into the checksum.
    - Next cycle: mem_we=1, mem_addr=addr counter, mem_wdata={high, low}.
    - Increment the addr counter and decrement remaining.
    - remaining was 1 -> CHK, else -> HI.
  - CHK + transfer:
    - byte == running XOR -> DONE: done=1, cpu_rstn=1.
    - Otherwise -> ERR: err=1, cpu_rstn=0.
  - In both CHK cases busy=0.
- Entry into ERR from COUNT sets err=1 and busy=0.
- The addr counter is ADDR_W bits and cannot wrap, because N≤DEPTH.
- Words already written before an ERR remain in memory. The processor stays in reset until a later frame succeeds.
- A frame is never truncated by the loader. The source must complete it, or assert rst.

## Timing
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, busy=0, done=0, err=0.
- rst mid-frame: everything returns to reset values on the next edge, and no mem_we is issued after that edge.
- start -> COUNT on the next edge; byte_ready=1 from that cycle on.
- Max throughput is one byte per cycle. A word takes 2 cycles, and its write appears 1 cycle after the LO transfer. Consecutive mem_we pulses are ≥2 cycles apart.
- The last word's mem_we happens in the same cycle that byte_ready=1 in CHK. Its write completes even if the CHK byte transfers in that same cycle.
- done/err/cpu_rstn update on the edge that accepts the CHK byte, or the COUNT byte on error. A frame of N words with continuous valid takes 2N+2 transfer cycles after start.
- byte_valid held high with byte_ready=0 causes no state change.

## Test plan
- Good 2-word frame: start, then 02, 1A,05, 1B,00, CHK=1A^05^1B^00=04 -> mem_we at addr0=0x1A05 and addr1=0x1B00; done=1, err=0, cpu_rstn=1 after the CHK edge.
- Bad checksum: same frame with CHK=05 -> both writes still occur; err=1, done=0, cpu_rstn=0.
- Illegal count: COUNT=00 and, separately, COUNT=21 (33) -> ERR immediately, no mem_we, byte_ready=0 afterwards.
- Full depth with gaps: N=32 with byte_valid randomly deasserted -> 32 writes to addr 0..31 with correct data, no extra writes, done=1.
- Reset mid-frame after 3 words: assert rst for 1 cycle -> all outputs reach reset values; a following good frame loads correctly from addr 0.
- Reload from DONE: start while done=1 -> cpu_rstn drops to 0 and done clears on the next edge; start pulses during HI are ignored.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The master side is the host/byte source plus memory/CPU observer.
// The slave side is the loader itself.
interface prog_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_rstn;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, busy, done, err
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader.
// Frame format: COUNT, then N x (HI, LO), then an XOR checksum over the 2N data bytes.
// Each word is written to program RAM one cycle after its LO byte.
// The CPU is held in reset until a frame passes its checksum.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    localparam int REM_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        chk_q, chk_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rstn_q, rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;

    // Next-state and registered-output computation for the frame parser
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        rstn_d  = rstn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        xfer    = bus.byte_valid && ready_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_COUNT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    rstn_d  = 1'b0;
                    addr_d  = '0;
                    chk_d   = 8'h00;
                    busy_d  = 1'b1;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    if (bus.byte_data == 8'h00 || int'(bus.byte_data) > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        rstn_d  = 1'b0;
                    end else begin
                        rem_d   = REM_W'(bus.byte_data);
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = bus.byte_data;
                    chk_d   = chk_q ^ bus.byte_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    chk_d   = chk_q ^ bus.byte_data;
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = {hi_q, bus.byte_data};
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - REM_W'(1);
                    state_d = (rem_q == REM_W'(1)) ? S_CHK : S_HI;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    busy_d = 1'b0;
                    if (bus.byte_data == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        rstn_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        rstn_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // byte_ready follows the state being entered, so it is a pure Moore output
        ready_d = (state_d == S_COUNT) || (state_d == S_HI) ||
                  (state_d == S_LO)    || (state_d == S_CHK);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            hi_q    <= 8'h00;
            chk_q   <= 8'h00;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= 16'h0000;
            rstn_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            chk_q   <= chk_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_rstn   = rstn_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader.
// The frame-level model predicts the write list and the status flags.
// A negedge process compares every output against it each cycle.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(5)) bif();
    prog_loader #(.ADDR_W(5), .DEPTH(32)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [4:0] a; logic [15:0] d; } wr_t;
    wr_t        exp_wr[$];
    wr_t        cw;
    logic       exp_ready = 0, exp_busy = 0, exp_done = 0, exp_err = 0, exp_rstn = 0;
    logic [15:0] mem_img [32];
    int         wr_seen = 0;
    logic [7:0] fb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("byte_ready", {31'b0, bif.byte_ready}, {31'b0, exp_ready});
        chk("busy",       {31'b0, bif.busy},       {31'b0, exp_busy});
        chk("done",       {31'b0, bif.done},       {31'b0, exp_done});
        chk("err",        {31'b0, bif.err},        {31'b0, exp_err});
        chk("cpu_rstn",   {31'b0, bif.cpu_rstn},   {31'b0, exp_rstn});
        if (bif.mem_we === 1'b1) begin
            wr_seen++;
            mem_img[bif.mem_addr] = bif.mem_wdata;
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: addr %0d data %h, none expected", bif.mem_addr, bif.mem_wdata);
            end else begin
                cw = exp_wr.pop_front();
                chk("mem_addr",  {27'b0, bif.mem_addr}, {27'b0, cw.a});
                chk("mem_wdata", {16'b0, bif.mem_wdata}, {16'b0, cw.d});
            end
        end else begin
            chk("mem_we_idle", {31'b0, bif.mem_we}, 32'd0);
        end
    end

    function automatic logic [7:0] frame_chk(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 2 * n; i++) x ^= fb[i];
        return x;
    endfunction

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        int n = 0;
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        while (bif.byte_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL put_byte_timeout: byte %h never accepted", b);
            bif.byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'hA5;
    endtask

    task automatic pulse_start();
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        exp_done = 0; exp_err = 0; exp_rstn = 0; exp_busy = 1; exp_ready = 1;
        chk("start_busy", {31'b0, bif.busy}, 32'd1);
        chk("start_rstn", {31'b0, bif.cpu_rstn}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_done = 0; exp_err = 0; exp_rstn = 0; exp_busy = 0; exp_ready = 0;
        exp_wr.delete();
        rst = 1'b0;
    endtask

    // Sends one frame using the data bytes in fb.
    // chk_ovr < 0 means send the correct checksum.
    task automatic run_frame(input logic [7:0] cnt, input int chk_ovr, input int gapmax, input bit mid_start);
        logic [7:0] x = 8'h00;
        logic [7:0] c;
        wr_t w;
        wr_seen = 0;
        pulse_start();
        put_byte(cnt);
        if (cnt == 8'd0 || cnt > 8'd32) begin
            exp_err = 1; exp_busy = 0; exp_ready = 0;
            return;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            idle($urandom_range(0, gapmax));
            if (mid_start && i == 0) begin
                bif.start = 1'b1;
                @(posedge clk);
                #1;
                bif.start = 1'b0;
            end
            put_byte(fb[2*i]);
            x ^= fb[2*i];
            idle($urandom_range(0, gapmax));
            w.a = i[4:0];
            w.d = {fb[2*i], fb[2*i+1]};
            exp_wr.push_back(w);
            put_byte(fb[2*i+1]);
            x ^= fb[2*i+1];
        end
        idle($urandom_range(0, gapmax));
        c = (chk_ovr < 0) ? x : chk_ovr[7:0];
        put_byte(c);
        if (c == x) begin
            exp_done = 1; exp_rstn = 1;
        end else begin
            exp_err = 1;
        end
        exp_busy = 0; exp_ready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        rst = 1'b1;
        bif.start = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data = 8'h00;
        idle(2);
        rst = 1'b0;
        chk("rst_ready", {31'b0, bif.byte_ready}, 32'd0);
        chk("rst_we",    {31'b0, bif.mem_we}, 32'd0);
        chk("rst_addr",  {27'b0, bif.mem_addr}, 32'd0);
        chk("rst_wdata", {16'b0, bif.mem_wdata}, 32'd0);
        chk("rst_rstn",  {31'b0, bif.cpu_rstn}, 32'd0);
        idle(2);

        // Good 2-word frame
        fb = '{8'h1A, 8'h05, 8'h1B, 8'h00};
        chk("model_chk", {24'b0, frame_chk(2)}, 32'h04);
        run_frame(8'd2, -1, 0, 1'b0);
        idle(2);
        chk("t1_mem0",  {16'b0, mem_img[0]}, 32'h1A05);
        chk("t1_mem1",  {16'b0, mem_img[1]}, 32'h1B00);
        chk("t1_done",  {31'b0, bif.done}, 32'd1);
        chk("t1_rstn",  {31'b0, bif.cpu_rstn}, 32'd1);
        chk("t1_nwr",   wr_seen, 32'd2);

        // Bad checksum: writes still happen
        run_frame(8'd2, 8'h05, 0, 1'b0);
        idle(2);
        chk("t2_err",  {31'b0, bif.err}, 32'd1);
        chk("t2_done", {31'b0, bif.done}, 32'd0);
        chk("t2_rstn", {31'b0, bif.cpu_rstn}, 32'd0);
        chk("t2_nwr",  wr_seen, 32'd2);

        // Illegal counts
        run_frame(8'h00, -1, 0, 1'b0);
        idle(3);
        chk("t3a_err",   {31'b0, bif.err}, 32'd1);
        chk("t3a_ready", {31'b0, bif.byte_ready}, 32'd0);
        chk("t3a_nwr",   wr_seen, 32'd0);
        run_frame(8'h21, -1, 0, 1'b0);
        idle(3);
        chk("t3b_err",   {31'b0, bif.err}, 32'd1);
        chk("t3b_ready", {31'b0, bif.byte_ready}, 32'd0);
        chk("t3b_nwr",   wr_seen, 32'd0);

        // Full depth with random gaps
        fb.delete();
        for (int i = 0; i < 64; i++) fb.push_back(8'($urandom_range(0, 255)));
        run_frame(8'd32, -1, 2, 1'b0);
        idle(2);
        chk("t4_nwr",   wr_seen, 32'd32);
        chk("t4_done",  {31'b0, bif.done}, 32'd1);
        chk("t4_last",  {16'b0, mem_img[31]}, {16'b0, fb[62], fb[63]});
        chk("t4_qleft", exp_wr.size(), 32'd0);

        // Reset mid-frame after 3 words
        pulse_start();
        put_byte(8'd5);
        for (int i = 0; i < 3; i++) begin
            put_byte(8'h30 + 8'(i));
            w.a = i[4:0];
            w.d = {8'h30 + 8'(i), 8'h40 + 8'(i)};
            exp_wr.push_back(w);
            put_byte(8'h40 + 8'(i));
        end
        idle(2);
        chk("t5_partial", exp_wr.size(), 32'd0);
        do_reset();
        idle(1);
        chk("t5_busy",  {31'b0, bif.busy}, 32'd0);
        chk("t5_ready", {31'b0, bif.byte_ready}, 32'd0);
        chk("t5_rstn",  {31'b0, bif.cpu_rstn}, 32'd0);
        chk("t5_done",  {31'b0, bif.done}, 32'd0);
        fb = '{8'hC3, 8'h7E};
        run_frame(8'd1, -1, 0, 1'b0);
        idle(2);
        chk("t5_mem0", {16'b0, mem_img[0]}, 32'hC37E);
        chk("t5_ok",   {31'b0, bif.done}, 32'd1);

        // Reload from DONE with a stray start during HI
        fb = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_frame(8'd2, -1, 1, 1'b1);
        idle(2);
        chk("t6_mem1", {16'b0, mem_img[1]}, 32'h5678);
        chk("t6_done", {31'b0, bif.done}, 32'd1);
        chk("t6_nwr",  wr_seen, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
